// File: rtl/enemy_scheduler.sv
// Four-slot enemy lifecycle scheduler with a round-robin collision arbiter.
// Optional scroll-out despawn is compiled in with ENEMY_SCHED_DESPAWN_EN.

module enemy_slot #(
   parameter logic [17:0] SPAWN_X       = 18'd1696,
   parameter int          SCREEN_W      = 640,
   parameter int          SQUASH_FRAMES = 30
) (
   input  logic        frame_clk,
   input  logic        clear,
   input  logic [17:0] background_offset,
   input  logic        granted,
   input  logic        stomp,
   output logic        active,
   output logic        en,
   output logic        visible,
   output logic        rst
);
   typedef enum logic [1:0] {DORMANT, ACTIVE, SQUASH, DEAD} slot_state_t;

   slot_state_t cur, nxt;
   logic [4:0]  cnt, cnt_nxt;
   logic        spawn_hit;

   // 19-bit sum so a large offset cannot wrap past the spawn point
   assign spawn_hit = ({1'b0, background_offset} + 19'(SCREEN_W)) >= {1'b0, SPAWN_X};
`ifdef ENEMY_SCHED_DESPAWN_EN
   logic despawn_hit;
   assign despawn_hit = {1'b0, background_offset} > ({1'b0, SPAWN_X} + 19'(SCREEN_W));
`endif

   always_comb begin
      nxt     = cur;
      cnt_nxt = cnt;
      unique case (cur)
         DORMANT: if (spawn_hit) nxt = ACTIVE;
         ACTIVE: begin
            if (granted && stomp) begin
               nxt     = SQUASH;
               cnt_nxt = 5'(SQUASH_FRAMES - 1);
            end
`ifdef ENEMY_SCHED_DESPAWN_EN
            else if (!granted && despawn_hit) nxt = DEAD;
`endif
         end
         SQUASH: begin
            if (cnt == 5'd0) nxt = DEAD;
            else             cnt_nxt = cnt - 5'd1;
         end
         default: nxt = cur;
      endcase
   end

   always_ff @(posedge frame_clk) begin
      if (clear) begin
         cur     <= DORMANT;
         cnt     <= '0;
         en      <= 1'b0;
         visible <= 1'b0;
         rst     <= 1'b1;
      end else begin
         cur     <= nxt;
         cnt     <= cnt_nxt;
         en      <= (nxt == ACTIVE);
         visible <= (nxt == ACTIVE) || (nxt == SQUASH);
         rst     <= (nxt == DORMANT) || (nxt == DEAD);
      end
   end

   assign active = (cur == ACTIVE);
endmodule

module enemy_scheduler #(
   parameter logic [17:0] SPAWN_X0      = 18'd1696,
   parameter logic [17:0] SPAWN_X1      = 18'd2400,
   parameter logic [17:0] SPAWN_X2      = 18'd3200,
   parameter logic [17:0] SPAWN_X3      = 18'd4000,
   parameter int          SCREEN_W      = 640,
   parameter int          SQUASH_FRAMES = 30
) (
   input  logic        frame_clk,
   input  logic        Reset,
   input  logic [1:0]  state,
   input  logic [17:0] background_offset,
   input  logic [3:0]  stomp_req,
   input  logic [3:0]  hit_req,
   output logic [3:0]  enemy_en,
   output logic [3:0]  enemy_visible,
   output logic [3:0]  enemy_rst,
   output logic [3:0]  grant,
   output logic        bounce,
   output logic        mario_kill
);
   localparam logic [3:0][17:0] SPAWN_X = {SPAWN_X3, SPAWN_X2, SPAWN_X1, SPAWN_X0};

   logic       clear;
   logic [3:0] active, eligible, gnt_nxt;
   logic [1:0] rr, pick, idx;
   logic       found, kill_lock;

   // Leaving the play state wipes everything exactly like Reset
   assign clear    = Reset || (state != 2'b01);
   assign eligible = active & (stomp_req | hit_req) & {4{~kill_lock}};

   always_comb begin
      gnt_nxt = '0;
      found   = 1'b0;
      pick    = '0;
      idx     = '0;
      for (int k = 0; k < 4; k++) begin
         idx = rr + 2'(k);
         if (!found && eligible[idx]) begin
            found        = 1'b1;
            pick         = idx;
            gnt_nxt[idx] = 1'b1;
         end
      end
   end

   always_ff @(posedge frame_clk) begin
      if (clear) begin
         grant      <= '0;
         bounce     <= 1'b0;
         mario_kill <= 1'b0;
         rr         <= '0;
         kill_lock  <= 1'b0;
      end else begin
         grant      <= gnt_nxt;
         bounce     <= found && stomp_req[pick];
         mario_kill <= found && !stomp_req[pick];
         if (found) rr <= pick + 2'd1;
         if (found && !stomp_req[pick]) kill_lock <= 1'b1;
      end
   end

   for (genvar g = 0; g < 4; g++) begin : g_slot
      enemy_slot #(
         .SPAWN_X       (SPAWN_X[g]),
         .SCREEN_W      (SCREEN_W),
         .SQUASH_FRAMES (SQUASH_FRAMES)
      ) u_slot (
         .frame_clk         (frame_clk),
         .clear             (clear),
         .background_offset (background_offset),
         .granted           (gnt_nxt[g]),
         .stomp             (stomp_req[g]),
         .active            (active[g]),
         .en                (enemy_en[g]),
         .visible           (enemy_visible[g]),
         .rst               (enemy_rst[g])
      );
   end
endmodule

// File: tb/tb_enemy_scheduler.sv
// Directed and randomized checks of enemy_scheduler against a slot-lifecycle model.
module tb_enemy_scheduler;
   logic        frame_clk = 1'b0;
   logic        Reset = 1'b1;
   logic [1:0]  state = 2'b00;
   logic [17:0] background_offset = '0;
   logic [3:0]  stomp_req = '0, hit_req = '0;
   logic [3:0]  enemy_en, enemy_visible, enemy_rst, grant;
   logic        bounce, mario_kill;

   int errors = 0;
   int checks = 0;

   always #5 frame_clk = ~frame_clk;

   enemy_scheduler dut (
      .frame_clk         (frame_clk),
      .Reset             (Reset),
      .state             (state),
      .background_offset (background_offset),
      .stomp_req         (stomp_req),
      .hit_req           (hit_req),
      .enemy_en          (enemy_en),
      .enemy_visible     (enemy_visible),
      .enemy_rst         (enemy_rst),
      .grant             (grant),
      .bounce            (bounce),
      .mario_kill        (mario_kill)
   );

   // Model: 0 dormant, 1 active, 2 squashed, 3 dead
   int         SPAWN [4] = '{1696, 2400, 3200, 4000};
   int         m_st [4];
   int         m_rem [4];
   int         m_rr;
   bit         m_lock;
   logic [3:0] m_grant;
   logic       m_bounce, m_kill;

   task automatic model_step(bit r, logic [1:0] s, int off, logic [3:0] st, logic [3:0] hi);
      int g;
      g = -1;
      if (r || s != 2'b01) begin
         for (int i = 0; i < 4; i++) begin m_st[i] = 0; m_rem[i] = 0; end
         m_rr = 0; m_lock = 0; m_grant = '0; m_bounce = 0; m_kill = 0;
         return;
      end
      if (!m_lock)
         for (int k = 0; k < 4; k++) begin
            int j;
            j = (m_rr + k) % 4;
            if (g < 0 && m_st[j] == 1 && (st[j] || hi[j])) g = j;
         end
      m_grant  = (g >= 0) ? 4'(1 << g) : 4'b0;
      m_bounce = (g >= 0) && st[g];
      m_kill   = (g >= 0) && !st[g];
      if (g >= 0) begin
         m_rr = (g + 1) % 4;
         if (!st[g]) m_lock = 1;
      end
      for (int i = 0; i < 4; i++) begin
         case (m_st[i])
            0: if (off + 640 >= SPAWN[i]) m_st[i] = 1;
            1: begin
               if (i == g && st[i]) begin m_st[i] = 2; m_rem[i] = 30; end
`ifdef ENEMY_SCHED_DESPAWN_EN
               else if (i != g && off > SPAWN[i] + 640) m_st[i] = 3;
`endif
            end
            2: begin
               m_rem[i]--;
               if (m_rem[i] == 0) m_st[i] = 3;
            end
            default: ;
         endcase
      end
   endtask

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(bit r, logic [1:0] s, int off, logic [3:0] st, logic [3:0] hi, string tag);
      logic [3:0] e_en, e_vis, e_rst;
      Reset = r; state = s; background_offset = 18'(off); stomp_req = st; hit_req = hi;
      model_step(r, s, off, st, hi);
      @(posedge frame_clk); #1;
      for (int i = 0; i < 4; i++) begin
         e_en[i]  = (m_st[i] == 1);
         e_vis[i] = (m_st[i] == 1) || (m_st[i] == 2);
         e_rst[i] = (m_st[i] == 0) || (m_st[i] == 3);
      end
      chk(tag, {14'd0, enemy_en, enemy_visible, enemy_rst, grant, bounce, mario_kill},
               {14'd0, e_en, e_vis, e_rst, m_grant, m_bounce, m_kill});
   endtask

   initial begin
      int off;
      #1;
      // reset state
      tick(1, 2'b01, 0, 4'h0, 4'h0, "reset");
      tick(1, 2'b01, 0, 4'h0, 4'h0, "reset2");
      chk("reset_outs", {20'd0, enemy_en, enemy_visible, enemy_rst}, 32'h00F);

      // spawn threshold: 1055 stays dormant, 1056 activates slot 0
      tick(0, 2'b01, 1055, 4'h0, 4'h0, "pre_spawn");
      chk("pre_spawn_en", {28'd0, enemy_en}, 32'h0);
      tick(0, 2'b01, 1056, 4'h0, 4'h0, "spawn");
      chk("spawn_en_rst", {24'd0, enemy_en, enemy_rst}, 32'h1E);

      // stomp beats hit, then 30 visible squash cycles
      tick(0, 2'b01, 1056, 4'h1, 4'h1, "stomp0");
      chk("stomp0_pulse", {26'd0, grant, bounce, mario_kill}, 32'b000110);
      for (int c = 0; c < 29; c++) begin
         tick(0, 2'b01, 1056, 4'h0, 4'h0, "squash");
         chk("squash_vis", {31'd0, enemy_visible[0]}, 32'd1);
      end
      tick(0, 2'b01, 1056, 4'h0, 4'h0, "squash_end");
      chk("squash_dead", {30'd0, enemy_visible[0], enemy_rst[0]}, 32'b01);

      // round robin over slots 0..2
      tick(1, 2'b01, 0, 4'h0, 4'h0, "rr_reset");
      tick(0, 2'b01, 2560, 4'h0, 4'h0, "rr_spawn");
      tick(0, 2'b01, 2560, 4'h7, 4'h0, "rr_g0");
`ifndef ENEMY_SCHED_DESPAWN_EN
      chk("rr_g0_lit", {28'd0, grant}, 32'h1);
`endif
      tick(0, 2'b01, 2560, 4'h7, 4'h0, "rr_g1");
`ifndef ENEMY_SCHED_DESPAWN_EN
      chk("rr_g1_lit", {28'd0, grant}, 32'h2);
`endif
      tick(0, 2'b01, 2560, 4'h7, 4'h0, "rr_g2");
`ifndef ENEMY_SCHED_DESPAWN_EN
      chk("rr_g2_lit", {28'd0, grant}, 32'h4);
`endif
      tick(0, 2'b01, 2560, 4'h7, 4'h0, "rr_none");

      // side hit locks out all later grants
      tick(1, 2'b01, 0, 4'h0, 4'h0, "kl_reset");
      tick(0, 2'b01, 1760, 4'h0, 4'h0, "kl_spawn");
      tick(0, 2'b01, 1760, 4'h0, 4'h2, "kl_hit");
      chk("kl_hit_lit", {26'd0, grant, bounce, mario_kill}, 32'b001001);
      for (int c = 0; c < 3; c++) begin
         tick(0, 2'b01, 1760, 4'h2, 4'h0, "kl_locked");
         chk("kl_locked_lit", {26'd0, grant, bounce, mario_kill}, 32'h0);
      end

      // state change mid-squash behaves as reset
      tick(1, 2'b01, 0, 4'h0, 4'h0, "sc_reset");
      tick(0, 2'b01, 1056, 4'h0, 4'h0, "sc_spawn");
      tick(0, 2'b01, 1056, 4'h1, 4'h0, "sc_stomp");
      for (int c = 0; c < 19; c++) tick(0, 2'b01, 1056, 4'h0, 4'h0, "sc_squash");
      tick(0, 2'b10, 1056, 4'h0, 4'h0, "sc_leave");
      chk("sc_leave_lit", {20'd0, enemy_en, enemy_visible, enemy_rst}, 32'h00F);
      tick(0, 2'b01, 1056, 4'h0, 4'h0, "sc_back");

      // scroll past slot 0
      tick(1, 2'b01, 0, 4'h0, 4'h0, "ds_reset");
      tick(0, 2'b01, 1056, 4'h0, 4'h0, "ds_spawn");
      tick(0, 2'b01, 2337, 4'h0, 4'h0, "ds_scroll");
`ifdef ENEMY_SCHED_DESPAWN_EN
      chk("ds_lit", {30'd0, enemy_en[0], enemy_rst[0]}, 32'b01);
`else
      chk("ds_lit", {30'd0, enemy_en[0], enemy_rst[0]}, 32'b10);
`endif

      // randomized play
      tick(1, 2'b01, 0, 4'h0, 4'h0, "rnd_reset");
      off = 1000;
      for (int c = 0; c < 600; c++) begin
         bit         r;
         logic [1:0] s;
         r = ($urandom_range(0, 79) == 0);
         s = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(0, 3)) : 2'b01;
         if ($urandom_range(0, 29) == 0) off = $urandom_range(0, 4200);
         else off = (off + $urandom_range(0, 12)) % 4400;
         tick(r, s, off, 4'($urandom) & 4'($urandom), 4'($urandom) & 4'($urandom) & 4'($urandom), "random");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
